// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one shift/correct step per clock.
// Optional digit-range check is enabled by defining BCD2BIN_ERRCHK_EN.
module bcd_to_binary_seq #(
  parameter int NUM_DIGITS = 3,
  parameter int BIN_W      = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [4*NUM_DIGITS-1:0] in_bcd_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [BIN_W-1:0]        out_bin_o,
  output logic                    out_err_o
);

  localparam int DIG_W  = 4 * NUM_DIGITS;
  localparam int SREG_W = DIG_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state_q, state_d;
  logic [SREG_W-1:0]   sreg_q, sreg_d, step;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIN_W-1:0]    out_bin_q, out_bin_d;

`ifdef BCD2BIN_ERRCHK_EN
  logic bad_q, bad_d;
  logic out_err_q, out_err_d;

  function automatic logic has_bad_digit(input logic [DIG_W-1:0] bcd);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction
`endif

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i) state_d = CONV;
      CONV:    if (cnt_q == CNT_W'(BIN_W)) state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
    out_bin_o   = out_bin_q;
`ifdef BCD2BIN_ERRCHK_EN
    out_err_o   = out_err_q;
`else
    out_err_o   = 1'b0;
`endif
  end

  // One step: shift right, then subtract 3 from every digit field that reached 8 or more
  always_comb begin
    step = sreg_q >> 1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (step[BIN_W+4*i +: 4] >= 4'd8)
        step[BIN_W+4*i +: 4] = step[BIN_W+4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    out_bin_d = out_bin_q;
`ifdef BCD2BIN_ERRCHK_EN
    bad_d     = bad_q;
    out_err_d = out_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          sreg_d = {in_bcd_i, {BIN_W{1'b0}}};
          cnt_d  = '0;
`ifdef BCD2BIN_ERRCHK_EN
          bad_d  = has_bad_digit(in_bcd_i);
`endif
        end
      end
      CONV: begin
        if (cnt_q == CNT_W'(BIN_W)) begin
`ifdef BCD2BIN_ERRCHK_EN
          out_bin_d = bad_q ? '0 : sreg_q[BIN_W-1:0];
          out_err_d = bad_q;
`else
          out_bin_d = sreg_q[BIN_W-1:0];
`endif
        end else begin
          sreg_d = step;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
`ifdef BCD2BIN_ERRCHK_EN
        if (out_ready_i) out_err_d = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sreg_q    <= '0;
      cnt_q     <= '0;
      out_bin_q <= '0;
`ifdef BCD2BIN_ERRCHK_EN
      bad_q     <= 1'b0;
      out_err_q <= 1'b0;
`endif
    end else begin
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      out_bin_q <= out_bin_d;
`ifdef BCD2BIN_ERRCHK_EN
      bad_q     <= bad_d;
      out_err_q <= out_err_d;
`endif
    end
  end

endmodule
